// File: rtl/y86_inst_encoder.sv
// Serialises decoded Y86-64 instruction fields into a byte-wide instruction memory, one byte per clock.
// Optional ifun legality checking is enabled by defining Y86_ENC_STRICT_IFUN_EN.
module y86_inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [63:0]       pc,
  output logic              done,
  output logic [2:0]        status_condition
);

  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [2:0] STAT_HLT = 3'b010;
  localparam logic [2:0] STAT_ADR = 3'b011;
  localparam logic [2:0] STAT_INS = 3'b100;
  localparam logic [ADDR_W:0] MEM_SIZE = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, EMIT, HALTED, ERROR} state_t;

  function automatic logic [3:0] inst_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       inst_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: inst_len = 4'd2;
      4'h7, 4'h8:             inst_len = 4'd9;
      4'h3, 4'h4, 4'h5:       inst_len = 4'd10;
      default:                inst_len = 4'd1;
    endcase
  endfunction

  function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7: ifun_legal = (fn <= 4'd6);
      4'h6:       ifun_legal = (fn <= 4'd3);
      default:    ifun_legal = (fn == 4'd0);
    endcase
  endfunction

  // Byte 0 lands in [7:0]; later bytes follow in ascending order.
  function automatic logic [79:0] pack_bytes(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [3:0] ra, input logic [3:0] rb,
                                             input logic [63:0] c);
    logic [79:0] b;
    b       = 80'd0;
    b[7:0]  = {ic, fn};
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: b[15:8] = {ra, rb};
      4'h3, 4'h4, 4'h5: begin
        b[15:8]  = {ra, rb};
        b[79:16] = c;
      end
      4'h7, 4'h8: b[71:8] = c;
      default:    b[15:8] = 8'd0;
    endcase
    pack_bytes = b;
  endfunction

  state_t          state_r;
  logic            in_ready_r;
  logic            mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]      mem_wdata_r;
  logic [ADDR_W:0] pc_r;
  logic            done_r;
  logic [2:0]      status_r;
  logic [79:0]     bytes_r;
  logic [3:0]      len_r;
  logic [3:0]      idx_r;
  logic            halt_r;

  logic [3:0]      len_s;
  logic [79:0]     bytes_s;
  logic [ADDR_W:0] end_addr_s;
  logic            bad_ins_s;
  logic            bad_adr_s;

  // Decode and legality checks on the fields presented at the input.
  always_comb begin
    len_s      = inst_len(icode);
    bytes_s    = pack_bytes(icode, ifun, rA, rB, valC);
    end_addr_s = pc_r + (ADDR_W+1)'(len_s);
`ifdef Y86_ENC_STRICT_IFUN_EN
    bad_ins_s  = (icode > 4'hB) || !ifun_legal(icode, ifun);
`else
    bad_ins_s  = (icode > 4'hB);
`endif
    bad_adr_s  = (end_addr_s > MEM_SIZE);
  end

  // Main sequencer: accept, emit bytes, track pc and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      pc_r        <= (ADDR_W+1)'(BASE_ADDR);
      done_r      <= 1'b0;
      status_r    <= STAT_AOK;
      bytes_r     <= 80'd0;
      len_r       <= 4'd0;
      idx_r       <= 4'd0;
      halt_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          if (in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            if (bad_ins_s) begin
              state_r  <= ERROR;
              status_r <= STAT_INS;
            end else if (bad_adr_s) begin
              state_r  <= ERROR;
              status_r <= STAT_ADR;
            end else begin
              state_r     <= EMIT;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= pc_r[ADDR_W-1:0];
              mem_wdata_r <= bytes_s[7:0];
              pc_r        <= pc_r + (ADDR_W+1)'(1);
              bytes_r     <= bytes_s >> 8;
              len_r       <= len_s;
              idx_r       <= 4'd1;
              halt_r      <= (icode == 4'h0);
              done_r      <= (len_s == 4'd1);
              if (icode == 4'h0) begin
                status_r <= STAT_HLT;
              end else begin
                status_r <= status_r;
              end
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        EMIT: begin
          if (idx_r == len_r) begin
            mem_we_r   <= 1'b0;
            done_r     <= 1'b0;
            state_r    <= halt_r ? HALTED : IDLE;
            in_ready_r <= !halt_r;
          end else begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= pc_r[ADDR_W-1:0];
            mem_wdata_r <= bytes_r[7:0];
            bytes_r     <= bytes_r >> 8;
            pc_r        <= pc_r + (ADDR_W+1)'(1);
            idx_r       <= idx_r + 4'd1;
            done_r      <= ((idx_r + 4'd1) == len_r);
          end
        end
        HALTED, ERROR: begin
          mem_we_r   <= 1'b0;
          done_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
        default: begin
          state_r    <= ERROR;
          mem_we_r   <= 1'b0;
          done_r     <= 1'b0;
          in_ready_r <= 1'b0;
          status_r   <= STAT_INS;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_r;
  assign mem_we           = mem_we_r;
  assign mem_addr         = mem_addr_r;
  assign mem_wdata        = mem_wdata_r;
  assign pc               = 64'(pc_r);
  assign done             = done_r;
  assign status_condition = status_r;

endmodule
